// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the Forth fetch/sequence controller: opcode bytes,
// controller state encoding and the inline-operand length rule.
package fetch_seq_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_DOLIT = 8'h02;
    localparam logic [7:0] OP_BRAN  = 8'h06;
    localparam logic [7:0] OP_ZBRAN = 8'h07;
    localparam logic [7:0] OP_EXIT  = 8'h0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DEC,
        S_ARG_RD,
        S_ARG_CAP,
        S_ISSUE
    } fseq_state_e;

    // Number of inline operand bytes that follow an opcode in memory.
    function automatic logic [2:0] arg_len(input logic [7:0] opcode);
        case (opcode)
            OP_DOLIT:          return 3'd4;
            OP_BRAN, OP_ZBRAN: return 3'd2;
            default:           return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch/sequence controller. Walks byte-wide opcode memory,
// gathers little-endian inline operands, offers one op at a time to exec
// and resolves branch / 0branch / exit locally.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int ASZ = 17,
    parameter int TSZ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic [ASZ-1:0] ip0,
    output logic           mem_re,
    output logic [ASZ-1:0] mem_addr,
    input  logic [7:0]     mem_rdata,
    output logic           op_valid,
    input  logic           op_ready,
    output logic [7:0]     op_code,
    output logic [DSZ-1:0] op_arg,
    output logic [ASZ-1:0] op_ip,
    input  logic           zflag,
    output logic           busy,
    output logic           done
);

    fseq_state_e    state, nxt;
    logic [ASZ-1:0] ip;
    logic [2:0]     cnt;
    logic [2:0]     byte_idx;
    logic [ASZ-1:0] target;
    logic           hshake;

    // Operand bytes arrive in ascending address order, so the first one
    // captured lands in byte 0 of op_arg.
    assign byte_idx = arg_len(op_code) - cnt;
    assign target   = ASZ'(op_arg[TSZ-1:0]);
    assign hshake   = (state == S_ISSUE) && op_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // Next-state selection and the state-decoded outputs.
    always_comb begin
        nxt      = state;
        mem_re   = 1'b0;
        mem_addr = '0;
        op_valid = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        case (state)
            S_IDLE:    if (start) nxt = S_FETCH;
            S_FETCH: begin
                mem_re   = 1'b1;
                mem_addr = ip;
                nxt      = S_DEC;
            end
            S_DEC:     nxt = (arg_len(mem_rdata) == 3'd0) ? S_ISSUE : S_ARG_RD;
            S_ARG_RD: begin
                mem_re   = 1'b1;
                mem_addr = ip;
                nxt      = S_ARG_CAP;
            end
            // cnt still holds the pre-decrement count here.
            S_ARG_CAP: nxt = (cnt > 3'd1) ? S_ARG_RD : S_ISSUE;
            S_ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    if (op_code == OP_EXIT) begin
                        nxt  = S_IDLE;
                        done = 1'b1;
                    end else begin
                        nxt = S_FETCH;
                    end
                end
            end
            default:   nxt = S_IDLE;
        endcase
        // Abort wins over everything else, including a same-cycle handshake.
        if (stop && (state != S_IDLE)) begin
            nxt  = S_IDLE;
            done = 1'b1;
        end
    end

    // Instruction pointer, operand counter and the presented op fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ip      <= '0;
            cnt     <= '0;
            op_code <= '0;
            op_arg  <= '0;
            op_ip   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) ip <= ip0;
                S_FETCH: begin
                    op_ip <= ip;
                    ip    <= ip + ASZ'(1);
                end
                S_DEC: begin
                    op_code <= mem_rdata;
                    op_arg  <= '0;
                    cnt     <= arg_len(mem_rdata);
                end
                S_ARG_RD:  ip <= ip + ASZ'(1);
                S_ARG_CAP: begin
                    op_arg <= op_arg | (DSZ'(mem_rdata) << {byte_idx, 3'b000});
                    cnt    <= cnt - 3'd1;
                end
                S_ISSUE: begin
                    // A not-taken 0branch leaves ip just past its operand.
                    if (hshake && !stop &&
                        ((op_code == OP_BRAN) || ((op_code == OP_ZBRAN) && zflag)))
                        ip <= target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed threads from the test plan, then random
// programs checked against an op-by-op interpreter of the opcode memory.
module tb_fetch_seq;

    localparam int DSZ = 32;
    localparam int ASZ = 17;
    localparam int TSZ = 16;

    localparam logic [7:0] C_NOP   = 8'h00;
    localparam logic [7:0] C_DOLIT = 8'h02;
    localparam logic [7:0] C_BRAN  = 8'h06;
    localparam logic [7:0] C_ZBRAN = 8'h07;
    localparam logic [7:0] C_EXIT  = 8'h0F;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [ASZ-1:0] ip0 = '0;
    logic           mem_re;
    logic [ASZ-1:0] mem_addr;
    logic [7:0]     mem_rdata = 8'h00;
    logic           op_valid;
    logic           op_ready = 1'b0;
    logic [7:0]     op_code;
    logic [DSZ-1:0] op_arg;
    logic [ASZ-1:0] op_ip;
    logic           zflag = 1'b0;
    logic           busy;
    logic           done;

    logic [7:0] mem [0:(1<<ASZ)-1];

    int n_cmp = 0;
    int n_bad = 0;

    logic [ASZ-1:0] fetch_log[$];
    logic [31:0]    arg_log[$];
    logic [ASZ-1:0] last_ip;

    fetch_seq #(.DSZ(DSZ), .ASZ(ASZ), .TSZ(TSZ)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ip0(ip0),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_arg(op_arg), .op_ip(op_ip), .zflag(zflag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read opcode memory: data is valid the cycle after mem_re.
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_len(input logic [7:0] c);
        if (c == C_DOLIT) return 4;
        if (c == C_BRAN || c == C_ZBRAN) return 2;
        return 0;
    endfunction

    // Runs one thread from a0. zmode: 0/1 constant zflag, 2 random.
    // The thread is aborted with stop on the handshake of op number max_ops.
    task automatic run_thread(input logic [ASZ-1:0] a0, input int max_ops,
                              input int zmode, input int max_wait);
        logic [ASZ-1:0] ipm, nip;
        logic [7:0]     code;
        logic [31:0]    arg;
        logic           z, stp, fin;
        int             n, cyc, waits, ops;
        fetch_log.delete();
        arg_log.delete();
        ipm = a0; ops = 0; fin = 1'b0;
        ip0 = a0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ip0 = ASZ'($urandom);
        while (!fin) begin
            code = mem[ipm];
            n    = model_len(code);
            arg  = '0;
            for (int k = 0; k < n; k++)
                arg = arg | (32'(mem[ipm + ASZ'(k + 1)]) << (8 * k));
            nip = ipm + ASZ'(n + 1);
            fetch_log.push_back(mem_addr);
            arg_log.push_back(arg);
            check("fetch_re", mem_re, 1);
            check("fetch_addr", mem_addr, ipm);
            cyc = 0;
            while (!op_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("latency", cyc, 2 + 2 * n);
            if (!op_valid) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                fin  = 1'b1;
            end else begin
                check("op_code", op_code, code);
                check("op_arg", op_arg, arg);
                check("op_ip", op_ip, ipm);
                waits = $urandom_range(0, max_wait);
                for (int w = 0; w < waits; w++) begin
                    @(negedge clk);
                    check("hold_valid", op_valid, 1);
                    check("hold_code", op_code, code);
                    check("hold_arg", op_arg, arg);
                    check("hold_re", mem_re, 0);
                end
                z   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
                stp = (ops + 1 >= max_ops) && (code != C_EXIT);
                op_ready = 1'b1; zflag = z; stop = stp;
                #1;
                check("done_hs", done, (code == C_EXIT) || stp);
                @(negedge clk);
                op_ready = 1'b0; stop = 1'b0; zflag = 1'b0;
                ops++;
                last_ip = ipm;
                if (code == C_EXIT || stp) begin
                    check("end_busy", busy, 0);
                    check("end_valid", op_valid, 0);
                    check("end_re", mem_re, 0);
                    check("end_done", done, 0);
                    fin = 1'b1;
                end else if (code == C_BRAN || (code == C_ZBRAN && z)) begin
                    ipm = ASZ'(arg[TSZ-1:0]);
                end else begin
                    ipm = nip;
                end
            end
        end
    endtask

    task automatic put(input logic [ASZ-1:0] a, input logic [7:0] b);
        mem[a] = b;
    endtask

    initial begin
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = C_NOP;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_re", mem_re, 0);
        check("rst_valid", op_valid, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_ip", op_ip, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // stop while idle does nothing
        stop = 1'b1; #1;
        check("idle_stop_done", done, 0);
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);

        // NOP then EXIT
        put(17'h100, C_NOP); put(17'h101, C_EXIT);
        run_thread(17'h100, 100, 0, 0);
        check("t1_nops", fetch_log.size(), 2);
        check("t1_exit_ip", last_ip, 17'h101);

        // dolit
        put(17'h100, C_DOLIT); put(17'h101, 8'h78); put(17'h102, 8'h56);
        put(17'h103, 8'h34); put(17'h104, 8'h12); put(17'h105, C_EXIT);
        run_thread(17'h100, 100, 0, 2);
        check("t2_lit", arg_log[0], 32'h12345678);
        check("t2_exit_ip", last_ip, 17'h105);

        // branch
        put(17'h100, C_BRAN); put(17'h101, 8'h10); put(17'h102, 8'h02);
        put(17'h210, C_EXIT);
        run_thread(17'h100, 100, 0, 0);
        check("t3_tgt", arg_log[0], 32'h210);
        check("t3_fetch", fetch_log[1], 17'h210);
        check("t3_exit_ip", last_ip, 17'h210);

        // 0branch, both outcomes
        put(17'h100, C_ZBRAN); put(17'h101, 8'h00); put(17'h102, 8'h03);
        put(17'h103, C_EXIT); put(17'h300, C_EXIT);
        run_thread(17'h100, 100, 0, 0);
        check("t4_nz_fetch", fetch_log[1], 17'h103);
        run_thread(17'h100, 100, 1, 0);
        check("t4_z_fetch", fetch_log[1], 17'h300);

        // stall in ISSUE, then stop
        put(17'h100, C_NOP); put(17'h101, C_EXIT);
        ip0 = 17'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid", op_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_valid", op_valid, 1);
            check("t5_hold_ip", op_ip, 17'h100);
            check("t5_hold_arg", op_arg, 0);
            check("t5_hold_re", mem_re, 0);
        end
        stop = 1'b1; #1;
        check("t5_done", done, 1);
        @(negedge clk);
        stop = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_valid_drop", op_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_fetch", mem_re, 0);
        end

        // address wrap
        put(17'h1FFFF, C_NOP); put(17'h00000, C_EXIT);
        run_thread(17'h1FFFF, 100, 0, 0);
        check("t6_wrap", fetch_log[1], 17'h00000);
        put(17'h00000, C_NOP);

        // asynchronous reset during operand capture
        put(17'h100, C_DOLIT); put(17'h101, 8'h78); put(17'h102, 8'h56);
        put(17'h103, 8'h34); put(17'h104, 8'h12); put(17'h105, C_EXIT);
        ip0 = 17'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_pre_code", op_code, C_DOLIT);
        rst = 1'b0; #1;
        check("t7_busy", busy, 0);
        check("t7_code", op_code, 0);
        check("t7_re", mem_re, 0);
        check("t7_done", done, 0);
        check("t7_valid", op_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t7_idle", busy, 0);

        // random programs
        for (int i = 0; i < (1 << ASZ); i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 12)      mem[i] = C_DOLIT;
            else if (r < 22) mem[i] = C_BRAN;
            else if (r < 32) mem[i] = C_ZBRAN;
            else if (r < 42) mem[i] = C_EXIT;
            else             mem[i] = 8'($urandom);
        end
        for (int t = 0; t < 40; t++)
            run_thread(ASZ'($urandom), $urandom_range(1, 20), 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
